// File: rtl/rx_buffer_ctrl.sv
// Receive-buffer controller: packs the MAC byte stream into 32-bit words and
// writes whole frames into a ping-pong two-bank frame RAM owned in turn by the CPU.
module rx_buffer_ctrl #(
   parameter int OCT    = 8,
   parameter int BUF_AW = 9,
   parameter int LEN_W  = BUF_AW + 3
) (
   input  logic              RX_CLK,
   input  logic              rst,
   input  logic              rx_data_v,
   input  logic [OCT-1:0]    rx_data,
   input  logic              rx_frame_done,
   output logic              ram_we,
   output logic [3:0]        ram_sel,
   output logic [BUF_AW:0]   ram_addr,
   output logic [4*OCT-1:0]  ram_wdata,
   output logic [1:0]        buf_ready,
   output logic [LEN_W-1:0]  buf_len0,
   output logic [LEN_W-1:0]  buf_len1,
   input  logic [1:0]        buf_release,
   input  logic              irq_en,
   output logic              rx_buf_irq,
   output logic [15:0]       drop_cnt,
   output logic [15:0]       ovf_cnt
);

   localparam logic [LEN_W-1:0] BUF_BYTES = LEN_W'(4 << BUF_AW);

   typedef enum logic [1:0] {IDLE, FILL, COMMIT, DROP} state_t;

   state_t             state_reg, state_next;
   logic               wr_bank_reg, wr_bank_next;
   logic [LEN_W-1:0]   byte_cnt_reg, byte_cnt_next;
   logic [4*OCT-1:0]   pack_reg, pack_next;
   logic               ram_we_reg, ram_we_next;
   logic [3:0]         ram_sel_reg, ram_sel_next;
   logic [BUF_AW:0]    ram_addr_reg, ram_addr_next;
   logic [4*OCT-1:0]   ram_wdata_reg, ram_wdata_next;
   logic [1:0]         buf_ready_reg, buf_ready_next;
   logic [LEN_W-1:0]   buf_len0_reg, buf_len0_next;
   logic [LEN_W-1:0]   buf_len1_reg, buf_len1_next;
   logic               irq_reg, irq_next;
   logic [15:0]        drop_cnt_reg, drop_cnt_next;
   logic [15:0]        ovf_cnt_reg, ovf_cnt_next;

   logic [1:0]         lane;
   logic [4*OCT-1:0]   pack_fill;
   logic [BUF_AW:0]    word_addr;

   assign lane      = byte_cnt_reg[1:0];
   assign word_addr = {wr_bank_reg, byte_cnt_reg[BUF_AW+1:2]};

   // Pack register with the incoming byte merged into its lane.
   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign pack_fill[OCT*gi +: OCT] = (lane == 2'(gi)) ? rx_data : pack_reg[OCT*gi +: OCT];
   end

   always_ff @(posedge RX_CLK or posedge rst) begin
      if (rst) begin
         state_reg     <= IDLE;
         wr_bank_reg   <= 1'b0;
         byte_cnt_reg  <= '0;
         pack_reg      <= '0;
         ram_we_reg    <= 1'b0;
         ram_sel_reg   <= '0;
         ram_addr_reg  <= '0;
         ram_wdata_reg <= '0;
         buf_ready_reg <= '0;
         buf_len0_reg  <= '0;
         buf_len1_reg  <= '0;
         irq_reg       <= 1'b0;
         drop_cnt_reg  <= '0;
         ovf_cnt_reg   <= '0;
      end else begin
         state_reg     <= state_next;
         wr_bank_reg   <= wr_bank_next;
         byte_cnt_reg  <= byte_cnt_next;
         pack_reg      <= pack_next;
         ram_we_reg    <= ram_we_next;
         ram_sel_reg   <= ram_sel_next;
         ram_addr_reg  <= ram_addr_next;
         ram_wdata_reg <= ram_wdata_next;
         buf_ready_reg <= buf_ready_next;
         buf_len0_reg  <= buf_len0_next;
         buf_len1_reg  <= buf_len1_next;
         irq_reg       <= irq_next;
         drop_cnt_reg  <= drop_cnt_next;
         ovf_cnt_reg   <= ovf_cnt_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      wr_bank_next   = wr_bank_reg;
      byte_cnt_next  = byte_cnt_reg;
      pack_next      = pack_reg;
      ram_we_next    = 1'b0;
      ram_sel_next   = ram_sel_reg;
      ram_addr_next  = ram_addr_reg;
      ram_wdata_next = ram_wdata_reg;
      buf_ready_next = buf_ready_reg & ~buf_release;
      buf_len0_next  = buf_len0_reg;
      buf_len1_next  = buf_len1_reg;
      drop_cnt_next  = drop_cnt_reg;
      ovf_cnt_next   = ovf_cnt_reg;

      case (state_reg)
         IDLE: begin
            if (rx_data_v) begin
               if (buf_ready_reg[wr_bank_reg]) begin
                  state_next = DROP;
                  if (drop_cnt_reg != 16'hFFFF) drop_cnt_next = drop_cnt_reg + 16'd1;
               end else begin
                  state_next    = FILL;
                  pack_next     = {{(3*OCT){1'b0}}, rx_data};
                  byte_cnt_next = LEN_W'(1);
               end
            end
         end
         FILL: begin
            if (rx_frame_done) begin
               state_next = COMMIT;
            end else if (rx_data_v) begin
               if (byte_cnt_reg == BUF_BYTES) begin
                  state_next    = DROP;
                  byte_cnt_next = '0;
                  pack_next     = '0;
                  if (ovf_cnt_reg != 16'hFFFF) ovf_cnt_next = ovf_cnt_reg + 16'd1;
               end else begin
                  byte_cnt_next = byte_cnt_reg + 1'b1;
                  if (lane == 2'd3) begin
                     ram_we_next    = 1'b1;
                     ram_sel_next   = 4'hF;
                     ram_addr_next  = word_addr;
                     ram_wdata_next = pack_fill;
                     pack_next      = '0;
                  end else begin
                     pack_next = pack_fill;
                  end
               end
            end
         end
         COMMIT: begin
            // Flush the trailing partial word; unwritten lanes are already zero.
            if (lane != 2'd0) begin
               ram_we_next    = 1'b1;
               ram_sel_next   = (4'b0001 << lane) - 4'd1;
               ram_addr_next  = word_addr;
               ram_wdata_next = pack_reg;
            end
            buf_ready_next[wr_bank_reg] = 1'b1;
            if (wr_bank_reg) buf_len1_next = byte_cnt_reg;
            else             buf_len0_next = byte_cnt_reg;
            wr_bank_next  = ~wr_bank_reg;
            byte_cnt_next = '0;
            pack_next     = '0;
            state_next    = IDLE;
         end
         DROP: begin
            if (rx_frame_done) begin
               state_next    = IDLE;
               byte_cnt_next = '0;
               pack_next     = '0;
            end
         end
         default: state_next = IDLE;
      endcase

      irq_next = irq_en & (|buf_ready_next);
   end

   assign ram_we     = ram_we_reg;
   assign ram_sel    = ram_sel_reg;
   assign ram_addr   = ram_addr_reg;
   assign ram_wdata  = ram_wdata_reg;
   assign buf_ready  = buf_ready_reg;
   assign buf_len0   = buf_len0_reg;
   assign buf_len1   = buf_len1_reg;
   assign rx_buf_irq = irq_reg;
   assign drop_cnt   = drop_cnt_reg;
   assign ovf_cnt    = ovf_cnt_reg;

endmodule

// File: tb/tb_rx_buffer_ctrl.sv
// Directed bench for rx_buffer_ctrl: frames are streamed byte by byte and every
// RAM write is logged on the falling edge for later comparison.
module tb_rx_buffer_ctrl;

   logic        RX_CLK = 1'b0;
   logic        rst;
   logic        rx_data_v;
   logic [7:0]  rx_data;
   logic        rx_frame_done;
   logic        ram_we;
   logic [3:0]  ram_sel;
   logic [9:0]  ram_addr;
   logic [31:0] ram_wdata;
   logic [1:0]  buf_ready;
   logic [11:0] buf_len0;
   logic [11:0] buf_len1;
   logic [1:0]  buf_release;
   logic        irq_en;
   logic        rx_buf_irq;
   logic [15:0] drop_cnt;
   logic [15:0] ovf_cnt;

   int checks   = 0;
   int failures = 0;

   logic [9:0]  log_addr  [2048];
   logic [3:0]  log_sel   [2048];
   logic [31:0] log_wdata [2048];
   int          wr_total = 0;

   rx_buffer_ctrl dut (
      .RX_CLK(RX_CLK), .rst(rst), .rx_data_v(rx_data_v), .rx_data(rx_data),
      .rx_frame_done(rx_frame_done), .ram_we(ram_we), .ram_sel(ram_sel),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .buf_ready(buf_ready),
      .buf_len0(buf_len0), .buf_len1(buf_len1), .buf_release(buf_release),
      .irq_en(irq_en), .rx_buf_irq(rx_buf_irq), .drop_cnt(drop_cnt), .ovf_cnt(ovf_cnt)
   );

   always #5 RX_CLK = ~RX_CLK;

   always @(negedge RX_CLK) begin
      if (ram_we === 1'b1 && wr_total < 2048) begin
         log_addr[wr_total]  = ram_addr;
         log_sel[wr_total]   = ram_sel;
         log_wdata[wr_total] = ram_wdata;
         wr_total++;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge RX_CLK);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      rx_data_v = 1'b0; rx_data = 8'h00; rx_frame_done = 1'b0; buf_release = 2'b00;
      tick(); tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic send_bytes(input int n, input logic [7:0] start);
      for (int i = 0; i < n; i++) begin
         rx_data_v = 1'b1;
         rx_data   = start + 8'(i);
         tick();
      end
   endtask

   task automatic send_frame(input int n, input logic [7:0] start, input logic [1:0] rel);
      send_bytes(n, start);
      rx_data_v = 1'b0;
      tick();
      rx_frame_done = 1'b1;
      tick();
      rx_frame_done = 1'b0;
      buf_release   = rel;
      tick();
      buf_release   = 2'b00;
      tick();
   endtask

   initial begin
      int base;
      irq_en = 1'b1;
      do_reset();
      $display("reset state checked");
      chk("reset_ram_we", 64'(ram_we), 64'h0);
      chk("reset_ram_addr", 64'(ram_addr), 64'h0);
      chk("reset_buf_ready", 64'(buf_ready), 64'h0);
      chk("reset_irq", 64'(rx_buf_irq), 64'h0);
      chk("reset_counts", {32'h0, drop_cnt, ovf_cnt}, 64'h0);

      // 64-byte frame into an empty controller
      base = wr_total;
      send_frame(64, 8'h00, 2'b00);
      $display("frame 64 bytes: writes=%0d buf_ready=%b len0=%0d", wr_total - base, buf_ready, buf_len0);
      chk("f64_nwrites", 64'(wr_total - base), 64'd16);
      for (int i = 0; i < 16; i++) begin
         chk("f64_addr", 64'(log_addr[base+i]), 64'(i));
         chk("f64_sel", 64'(log_sel[base+i]), 64'hF);
      end
      chk("f64_word0", 64'(log_wdata[base]), 64'h03020100);
      chk("f64_word15", 64'(log_wdata[base+15]), 64'h3F3E3D3C);
      chk("f64_ready", 64'(buf_ready), 64'h1);
      chk("f64_len0", 64'(buf_len0), 64'd64);
      chk("f64_irq", 64'(rx_buf_irq), 64'h1);

      buf_release = 2'b01;
      tick();
      buf_release = 2'b00;
      tick();
      $display("release bank0: buf_ready=%b irq=%b", buf_ready, rx_buf_irq);
      chk("rel0_ready", 64'(buf_ready), 64'h0);
      chk("rel0_irq", 64'(rx_buf_irq), 64'h0);
      chk("rel0_len_held", 64'(buf_len0), 64'd64);

      // 5-byte frame with trailing partial word
      do_reset();
      base = wr_total;
      send_frame(5, 8'h00, 2'b00);
      $display("frame 5 bytes: writes=%0d len0=%0d", wr_total - base, buf_len0);
      chk("f5_nwrites", 64'(wr_total - base), 64'd2);
      chk("f5_w0", {22'h0, log_addr[base], log_sel[base], log_wdata[base]}, {22'h0, 10'h000, 4'hF, 32'h03020100});
      chk("f5_w1", {22'h0, log_addr[base+1], log_sel[base+1], log_wdata[base+1]}, {22'h0, 10'h001, 4'h1, 32'h00000004});
      chk("f5_len0", 64'(buf_len0), 64'd5);

      // second frame goes to bank1, third is dropped
      base = wr_total;
      send_frame(8, 8'h10, 2'b00);
      $display("frame 8 bytes bank1: writes=%0d buf_ready=%b len1=%0d", wr_total - base, buf_ready, buf_len1);
      chk("b1_nwrites", 64'(wr_total - base), 64'd2);
      chk("b1_addr0", 64'(log_addr[base]), 64'h200);
      chk("b1_word1", {22'h0, log_addr[base+1], log_wdata[base+1]}, {22'h0, 10'h201, 32'h17161514});
      chk("b1_len1", 64'(buf_len1), 64'd8);
      base = wr_total;
      send_frame(4, 8'h20, 2'b00);
      $display("frame 4 bytes no bank: writes=%0d drop_cnt=%0d buf_ready=%b", wr_total - base, drop_cnt, buf_ready);
      chk("drop_nwrites", 64'(wr_total - base), 64'd0);
      chk("drop_cnt", 64'(drop_cnt), 64'd1);
      chk("drop_ready", 64'(buf_ready), 64'h3);
      chk("drop_lens", {40'h0, buf_len0, buf_len1}, {40'h0, 12'd5, 12'd8});

      // overflow frame then a normal frame back into bank0
      do_reset();
      base = wr_total;
      send_frame(2049, 8'h00, 2'b00);
      $display("frame 2049 bytes: writes=%0d ovf_cnt=%0d buf_ready=%b", wr_total - base, ovf_cnt, buf_ready);
      chk("ovf_nwrites", 64'(wr_total - base), 64'd512);
      chk("ovf_last", {22'h0, log_addr[base+511], log_wdata[base+511]}, {22'h0, 10'h1FF, 32'hFFFEFDFC});
      chk("ovf_cnt", 64'(ovf_cnt), 64'd1);
      chk("ovf_ready", 64'(buf_ready), 64'h0);
      chk("ovf_drop_cnt", 64'(drop_cnt), 64'd0);
      base = wr_total;
      send_frame(60, 8'h40, 2'b00);
      $display("frame 60 bytes after ovf: writes=%0d addr0=%h len0=%0d", wr_total - base, log_addr[base], buf_len0);
      chk("post_ovf_nwrites", 64'(wr_total - base), 64'd15);
      chk("post_ovf_addr0", 64'(log_addr[base]), 64'h000);
      chk("post_ovf_len0", 64'(buf_len0), 64'd60);
      chk("post_ovf_ready", 64'(buf_ready), 64'h1);

      // release bank0 in the same cycle bank1 commits
      do_reset();
      send_frame(4, 8'h00, 2'b00);
      base = wr_total;
      send_frame(6, 8'h00, 2'b01);
      $display("frame 6 bytes with release: buf_ready=%b len1=%0d irq=%b", buf_ready, buf_len1, rx_buf_irq);
      chk("relc_ready", 64'(buf_ready), 64'h2);
      chk("relc_len1", 64'(buf_len1), 64'd6);
      chk("relc_partial", {22'h0, log_addr[base+1], log_sel[base+1], log_wdata[base+1]}, {22'h0, 10'h201, 4'h3, 32'h00000504});
      chk("relc_irq", 64'(rx_buf_irq), 64'h1);
      irq_en = 1'b0;
      tick();
      $display("irq_en=0: irq=%b", rx_buf_irq);
      chk("irq_masked", 64'(rx_buf_irq), 64'h0);

      // asynchronous reset in the middle of a frame
      irq_en = 1'b1;
      do_reset();
      send_frame(16, 8'h00, 2'b00);
      send_bytes(30, 8'h80);
      #1;
      rst = 1'b1;
      #1;
      $display("async reset mid-frame: buf_ready=%b len0=%0d addr=%h", buf_ready, buf_len0, ram_addr);
      chk("arst_ready", 64'(buf_ready), 64'h0);
      chk("arst_len0", 64'(buf_len0), 64'h0);
      chk("arst_ram", {22'h0, ram_addr, ram_wdata}, 64'h0);
      chk("arst_irq", 64'(rx_buf_irq), 64'h0);
      rx_data_v = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      base = wr_total;
      send_frame(20, 8'h00, 2'b00);
      $display("frame 20 bytes after reset: addr0=%h len0=%0d buf_ready=%b", log_addr[base], buf_len0, buf_ready);
      chk("arst_next_addr0", 64'(log_addr[base]), 64'h000);
      chk("arst_next_len0", 64'(buf_len0), 64'd20);
      chk("arst_next_ready", 64'(buf_ready), 64'h1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
